// File: rtl/io_operand_ctrl_if.sv
// Processor-side bus into the IO window.
// The CPU is master; io_operand_ctrl is slave.
interface io_operand_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        io_sel;

  modport master (
    output we, addr, wdata,
    input  rdata, io_sel
  );

  modport slave (
    input  we, addr, wdata,
    output rdata, io_sel
  );
endinterface

// File: rtl/io_operand_ctrl.sv
// Memory-mapped IO window: debounced push-button captures two
// switch operands; LED and display registers for output.
module io_operand_ctrl #(
  parameter logic [31:0] IO_BASE    = 32'h0000_0400,
  parameter int          DEB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  io_operand_ctrl_if.slave   bus,
  input  logic [9:0]         switches,
  input  logic               pb,
  output logic [9:0]         leds,
  output logic [15:0]        disp_data
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t      r_state, w_state_n, w_base;
  logic        r_pb_s1, r_pb_s2;
  logic [9:0]  r_sw_s1, r_sw_s2;
  logic        r_stable, r_stable_d;
  logic [CW-1:0] r_cnt;
  logic        r_ovf;
  logic [31:0] r_opa, r_opb;
  logic [9:0]  r_leds;
  logic [15:0] r_disp;

  logic        w_sel, w_wr, w_press;
  logic        w_ack, w_clr;
  logic        w_cap_a, w_cap_b, w_ovf_set;
  logic [2:0]  w_off;
  logic [31:0] w_sw_ext, w_rd;

  assign w_sel    = (bus.addr[31:5] == IO_BASE[31:5]);
  assign w_off    = bus.addr[4:2];
  assign w_wr     = bus.we & w_sel;
  assign w_ack    = w_wr & (w_off == 3'd3) & bus.wdata[0];
  assign w_clr    = w_wr & (w_off == 3'd3) & bus.wdata[1];
  assign w_press  = r_stable & ~r_stable_d;
  assign w_sw_ext = {{22{r_sw_s2[9]}}, r_sw_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb_s1    <= 1'b0;
      r_pb_s2    <= 1'b0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pb_s1    <= pb;
      r_pb_s2    <= r_pb_s1;
      r_sw_s1    <= switches;
      r_sw_s2    <= r_sw_s1;
      r_stable_d <= r_stable;
      // count only while the synced level disagrees
      if (r_pb_s2 != r_stable) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_stable <= r_pb_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_base    = w_ack ? EMPTY : r_state;
    w_state_n = w_base;
    w_cap_a   = 1'b0;
    w_cap_b   = 1'b0;
    w_ovf_set = 1'b0;
    if (w_press) begin
      unique case (w_base)
        EMPTY: begin
          w_cap_a   = 1'b1;
          w_state_n = HAVE_A;
        end
        HAVE_A: begin
          w_cap_b   = 1'b1;
          w_state_n = FULL;
        end
        FULL:    w_ovf_set = 1'b1;
        default: w_state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ovf   <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_leds  <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_clr)          r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      if (w_cap_a) r_opa <= w_sw_ext;
      if (w_cap_b) r_opb <= w_sw_ext;
      if (w_wr && w_off == 3'd4) r_leds <= bus.wdata[9:0];
      if (w_wr && w_off == 3'd5) r_disp <= bus.wdata[15:0];
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      (w_off == 3'd0): w_rd = {29'd0, r_ovf,
                               r_state == FULL,
                               r_state != EMPTY};
      (w_off == 3'd1): w_rd = r_opa;
      (w_off == 3'd2): w_rd = r_opb;
      (w_off == 3'd4): w_rd = {22'd0, r_leds};
      (w_off == 3'd5): w_rd = {16'd0, r_disp};
      default:         w_rd = '0;
    endcase
  end

  assign bus.rdata  = w_sel ? w_rd : 32'd0;
  assign bus.io_sel = w_sel;
  assign leds       = r_leds;
  assign disp_data  = r_disp;

endmodule

// File: tb/tb_io_operand_ctrl.sv
// Directed vector bench for io_operand_ctrl with a short
// debounce window so press sequences stay small.
module tb_io_operand_ctrl;

  localparam logic [31:0] B = 32'h0000_0400;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] switches;
  logic       pb;
  logic [9:0] leds;
  logic [15:0] disp_data;

  int total = 0;
  int bad   = 0;

  io_operand_ctrl_if bus ();

  io_operand_ctrl #(.IO_BASE(B), .DEB_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .switches  (switches),
    .pb        (pb),
    .leds      (leds),
    .disp_data (disp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        sel;
    logic [9:0]  ld;
    logic [15:0] dp;
  } vec_t;

  vec_t tv [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    chk(nm, bus.rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic press(input logic [9:0] sw,
                       input int hold);
    switches = sw;
    tick();
    tick();
    pb = 1'b1;
    repeat (hold) tick();
    pb = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    tv[0]  = '{0, B+32'h00, 0, 0, 1, 10'h000, 16'h0000};
    tv[1]  = '{0, B+32'h04, 0, 0, 1, 10'h000, 16'h0000};
    tv[2]  = '{0, B+32'h08, 0, 0, 1, 10'h000, 16'h0000};
    tv[3]  = '{0, 32'h0000_0000, 0, 0, 0, 10'h000, 16'h0000};
    tv[4]  = '{0, B+32'h20, 0, 0, 0, 10'h000, 16'h0000};
    tv[5]  = '{1, B+32'h10, 32'h0000_02A5, 0, 1,
               10'h2A5, 16'h0000};
    tv[6]  = '{0, B+32'h10, 0, 32'h2A5, 1,
               10'h2A5, 16'h0000};
    tv[7]  = '{1, B+32'h14, 32'h1234_ABCD, 0, 1,
               10'h2A5, 16'hABCD};
    tv[8]  = '{0, B+32'h14, 0, 32'hABCD, 1,
               10'h2A5, 16'hABCD};
    tv[9]  = '{1, B+32'h0C, 32'h0, 0, 1, 10'h2A5, 16'hABCD};
    tv[10] = '{1, B+32'h18, 32'hFFFF, 0, 1,
               10'h2A5, 16'hABCD};
    tv[11] = '{1, 32'h0000_0810, 32'h3FF, 0, 0,
               10'h2A5, 16'hABCD};
    tv[12] = '{0, B+32'h1C, 0, 0, 1, 10'h2A5, 16'hABCD};
    tv[13] = '{0, B-32'h4, 0, 0, 0, 10'h2A5, 16'hABCD};
    tv[14] = '{1, B+32'h10, 32'hFFFF_FC00, 32'h2A5, 1,
               10'h000, 16'hABCD};

    reset     = 1'b1;
    switches  = '0;
    pb        = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) tick();
    chk("rst_leds", {22'd0, leds}, 32'd0);
    chk("rst_disp", {16'd0, disp_data}, 32'd0);
    reset = 1'b0;
    rd("rst_status", B, 32'd0);
    rd("rst_opa", B+4, 32'd0);
    rd("rst_opb", B+8, 32'd0);

    for (int i = 0; i < 15; i++) begin
      bus.we    = tv[i].we;
      bus.addr  = tv[i].addr;
      bus.wdata = tv[i].wdata;
      #1;
      chk($sformatf("v%0d_rd", i), bus.rdata, tv[i].rd);
      chk($sformatf("v%0d_sel", i),
          {31'd0, bus.io_sel}, {31'd0, tv[i].sel});
      tick();
      chk($sformatf("v%0d_led", i),
          {22'd0, leds}, {22'd0, tv[i].ld});
      chk($sformatf("v%0d_disp", i),
          {16'd0, disp_data}, {16'd0, tv[i].dp});
    end
    bus.we = 1'b0;

    // exact press latency: 2 sync + 4 debounce + edge
    switches = 10'd9;
    tick();
    tick();
    pb = 1'b1;
    repeat (6) tick();
    rd("lat_early", B, 32'd0);
    tick();
    rd("lat_status", B, 32'd1);
    rd("lat_opa", B+4, 32'd9);
    repeat (3) tick();
    pb = 1'b0;
    repeat (8) tick();
    rd("release_status", B, 32'd1);

    press(10'd49, 10);
    rd("b_status", B, 32'd3);
    rd("b_opb", B+8, 32'd49);
    press(10'd5, 10);
    rd("ovf_status", B, 32'd7);
    rd("ovf_opa", B+4, 32'd9);
    rd("ovf_opb", B+8, 32'd49);
    wr(B+12, 32'd1);
    rd("ack_status", B, 32'd4);
    wr(B+12, 32'd2);
    rd("clr_status", B, 32'd0);

    press(10'h3F6, 10);
    rd("neg_status", B, 32'd1);
    rd("neg_opa", B+4, 32'hFFFF_FFF6);
    press(10'd7, 2);
    rd("short_status", B, 32'd1);
    rd("short_opb", B+8, 32'd49);

    press(10'h022, 10);
    rd("full2_status", B, 32'd3);
    switches = 10'h155;
    tick();
    tick();
    pb = 1'b1;
    repeat (6) tick();
    bus.we    = 1'b1;
    bus.addr  = B+12;
    bus.wdata = 32'd1;
    tick();
    bus.we = 1'b0;
    rd("coin_status", B, 32'd1);
    rd("coin_opa", B+4, 32'h155);
    rd("coin_opb", B+8, 32'h22);
    pb = 1'b0;
    repeat (8) tick();

    switches = 10'h0AA;
    tick();
    tick();
    pb = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    pb    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    rd("rstmid_status", B, 32'd0);
    rd("rstmid_opa", B+4, 32'd0);
    rd("rstmid_disp", B+20, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_operand_ctrl.md
IO_OPERAND_CTRL -- requirements
Module: io_operand_ctrl

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0000_0400, byte base address of the 32-byte peripheral window (must be 32-byte aligned).
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a push-button level change.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 SHALL have port we, input, 1 bit, processor memory write strobe (MemWrite).
REQ-006 SHALL have port addr, input, 32 bits, processor byte address (DataAdr).
REQ-007 SHALL have port wdata, input, 32 bits, processor write data.
REQ-008 SHALL have port rdata, output, 32 bits, peripheral read data (combinational).
REQ-009 SHALL have port io_sel, output, 1 bit, high when addr hits the window; the data memory uses it to select rdata over RAM and to block RAM writes.
REQ-010 SHALL have port switches, input, 10 bits, asynchronous slide switches.
REQ-011 SHALL have port pb, input, 1 bit, asynchronous push button, 1 = pressed.
REQ-012 SHALL have port leds, output, 10 bits, LED register.
REQ-013 SHALL have port disp_data, output, 16 bits, display value register, fed to the 7-segment decoders.

Function
REQ-014 SHALL assert io_sel = (addr[31:5] == IO_BASE[31:5]); offset = addr[4:2].
REQ-015 SHALL apply this register map by offset: 0 STATUS (R: bit0 a_valid, bit1 b_valid, bit2 overflow, rest 0); 1 OPA (R); 2 OPB (R); 3 CTRL (W: bit0 ack, bit1 clr_ovf; reads 0); 4 LEDS (R/W, bits 9:0); 5 DISP (R/W, bits 15:0); 6-7 read 0, writes ignored.
REQ-016 SHALL drive rdata = 0 whenever io_sel = 0, and shall ignore writes when io_sel = 0.
REQ-017 SHALL perform register writes on the rising edge where we & io_sel; new value visible on outputs and reads the following cycle.
REQ-018 SHALL synchronise pb and switches through two flip-flop stages each.
REQ-019 SHALL debounce: the stable level changes only after the synchronised pb differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-020 SHALL generate a one-cycle press event on the stable level's 0->1 transition; release generates no event.
REQ-021 SHALL implement capture FSM states EMPTY (a_valid=0, b_valid=0), HAVE_A (1,0), FULL (1,1).
REQ-022 SHALL on press in EMPTY: OPA <= sign-extended synchronised switches, go HAVE_A.
REQ-023 SHALL on press in HAVE_A: OPB <= sign-extended synchronised switches, go FULL.
REQ-024 SHALL on press in FULL: set overflow, keep OPA/OPB and state.
REQ-025 SHALL on CTRL write with bit0=1: go EMPTY from any state; OPA/OPB retain values.
REQ-026 SHALL on CTRL write with bit1=1: clear overflow; if press-overflow in the same cycle, clear wins.
REQ-027 SHALL on ack in the same cycle as a press: apply ack, then capture into OPA, resulting state HAVE_A.
REQ-028 SHALL sign-extend switches[9] into OPA/OPB bits 31:10.

Reset
REQ-029 SHALL on reset set state EMPTY, overflow 0, OPA 0, OPB 0, leds 0, disp_data 0, synchronisers 0, stable level 0, debounce count 0.
REQ-030 SHALL let reset override all writes and press events in the same cycle, including mid-capture (HAVE_A/FULL -> EMPTY).

Verification (DEB_CYCLES = 4)
REQ-031 SHALL cover: reset held 3 cycles -> leds=0, disp_data=0, STATUS/OPA/OPB reads 0; read outside window -> rdata=0, io_sel=0.
REQ-032 SHALL cover: switches=9, pb high 10 cycles then low -> STATUS=1, OPA=9 exactly 2+4 edges after first pb sample; switches=49, press -> STATUS=3, OPB=49.
REQ-033 SHALL cover: switches=10'h3F6, press from EMPTY -> OPA=32'hFFFF_FFF6; pb high only 2 cycles -> no capture.
REQ-034 SHALL cover: third press in FULL -> STATUS=7, OPA/OPB unchanged; CTRL write 1 -> STATUS=4; CTRL write 2 -> STATUS=0; CTRL=1 coincident with press -> STATUS=1, OPA=new switches.
REQ-035 SHALL cover: write LEDS 32'h0000_02A5 -> leds=10'h2A5 next cycle, read back 32'h2A5; write DISP 32'h1234_ABCD -> disp_data=16'hABCD; RAM write blocked (io_sel=1).
REQ-036 SHALL cover: reset asserted while HAVE_A with a press pending -> STATUS=0 after reset, no capture from that press.
